// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: wait-FSM states and
// register-address width.
package riscv_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for perf stats.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables/flushes for load-use stalls,
// taken-branch flushes and multi-cycle data-memory waits with timeout.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  load_e,
  input  logic                  pc_src_e,
  input  logic                  mem_req_m,
  input  logic                  mem_ready_m,
  output logic                  en_f,
  output logic                  en_d,
  output logic                  en_e,
  output logic                  en_m,
  output logic                  en_w,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  hz_state_t      state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           mem_stall, branch, load_use;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_m && !mem_ready_m) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_m) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WAIT_MAX) begin
          state_d = ERROR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem_stall = (state_q == IDLE     && mem_req_m && !mem_ready_m)
                   | (state_q == MEM_WAIT && !mem_ready_m)
                   | (state_q == ERROR);
  assign branch    = pc_src_e && !mem_stall;
  assign load_use  = load_e && (rd_e != '0) && (rd_e == rs1_d || rd_e == rs2_d)
                   && !pc_src_e && !mem_stall;

  // Reset overrides everything so the pipeline registers hold while reset is high.
  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_e    = 1'b1;
    en_m    = 1'b1;
    en_w    = 1'b1;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (reset || mem_stall) begin
      {en_f, en_d, en_e, en_m, en_w} = '0;
    end else if (branch) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      flush_e = 1'b1;
    end
  end

  assign mem_timeout = (state_q == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!en_f),
    .clr   (1'b0),
    .q     (stall_cycles)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1_d, rs2_d, rd_e;
  logic          load_e, pc_src_e, mem_req_m, mem_ready_m;
  logic          en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_timeout;
  logic [CW-1:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_e         (rd_e),
    .load_e       (load_e),
    .pc_src_e     (pc_src_e),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .en_f         (en_f),
    .en_d         (en_d),
    .en_e         (en_e),
    .en_m         (en_m),
    .en_w         (en_w),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  wire [4:0] en_v = {en_f, en_d, en_e, en_m, en_w};
  wire [1:0] fl_v = {flush_d, flush_e};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
    load_e = 1'b0; pc_src_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    tick(); tick(); #1;
    chk("rst_en",   32'(en_v), 32'h00);
    chk("rst_fl",   32'(fl_v), 32'h0);
    chk("rst_cnt",  32'(stall_cycles), 32'd0);
    chk("rst_to",   32'(mem_timeout), 32'd0);
    reset = 1'b0; #1;
    chk("rel_en",   32'(en_v), 32'h1f);

    // load-use on rs2
    tick();
    load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd3; rs2_d = 5'd5; #1;
    chk("lu_en",    32'(en_v), 32'h07);
    chk("lu_fl",    32'(fl_v), 32'h1);
    tick();
    load_e = 1'b0; #1;
    chk("lu_after", 32'(en_v), 32'h1f);
    chk("lu_cnt",   32'(stall_cycles), 32'd1);

    // x0 destination never stalls
    load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd7; #1;
    chk("x0_en",    32'(en_v), 32'h1f);
    chk("x0_fl",    32'(fl_v), 32'h0);

    // branch beats load-use
    tick();
    rd_e = 5'd5; rs1_d = 5'd5; pc_src_e = 1'b1; #1;
    chk("br_en",    32'(en_v), 32'h1f);
    chk("br_fl",    32'(fl_v), 32'h3);
    tick();
    idle_in(); #1;
    chk("br_cnt",   32'(stall_cycles), 32'd1);

    // memory wait: 3 stalled cycles then release on ready
    mem_req_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_en", 32'(en_v), 32'h00);
      tick();
    end
    mem_ready_m = 1'b1; #1;
    chk("mw_rel",   32'(en_v), 32'h1f);
    chk("mw_cnt",   32'(stall_cycles), 32'd4);
    tick();
    mem_req_m = 1'b0; mem_ready_m = 1'b0; #1;
    chk("mw_idle",  32'(en_v), 32'h1f);

    // ready in the request cycle: no stall, stays IDLE
    mem_req_m = 1'b1; mem_ready_m = 1'b1; #1;
    chk("same_rdy", 32'(en_v), 32'h1f);
    tick();
    mem_req_m = 1'b0; mem_ready_m = 1'b0; #1;
    chk("same_idl", 32'(en_v), 32'h1f);
    chk("same_cnt", 32'(stall_cycles), 32'd4);

    // memory stall beats branch; branch taken on release cycle
    mem_req_m = 1'b1; pc_src_e = 1'b1; #1;
    chk("ms_br_en", 32'(en_v), 32'h00);
    chk("ms_br_fl", 32'(fl_v), 32'h0);
    tick();
    mem_ready_m = 1'b1; #1;
    chk("rel_br_en", 32'(en_v), 32'h1f);
    chk("rel_br_fl", 32'(fl_v), 32'h3);
    tick();
    idle_in(); #1;
    chk("rel_cnt",  32'(stall_cycles), 32'd5);

    // timeout: ERROR after 5th stalled cycle with MEM_TIMEOUT=4
    mem_req_m = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("to_pre",   32'(mem_timeout), 32'd0);
    chk("to_pre_en", 32'(en_v), 32'h00);
    tick();
    chk("to_set",   32'(mem_timeout), 32'd1);
    chk("to_cnt",   32'(stall_cycles), 32'd10);
    mem_ready_m = 1'b1; #1;
    chk("to_frz",   32'(en_v), 32'h00);
    for (int i = 0; i < 8; i++) tick();
    chk("to_stky",  32'(mem_timeout), 32'd1);
    chk("cnt_sat",  32'(stall_cycles), 32'd15);
    reset = 1'b1; #1;
    chk("to_rst",   32'(mem_timeout), 32'd0);
    chk("to_rcnt",  32'(stall_cycles), 32'd0);
    tick();
    idle_in(); reset = 1'b0; #1;
    chk("to_rel",   32'(en_v), 32'h1f);

    // async reset mid-MEM_WAIT, between edges
    mem_req_m = 1'b1;
    tick(); tick();
    chk("ar_wait",  32'(en_v), 32'h00);
    #3 reset = 1'b1; #1;
    chk("ar_en",    32'(en_v), 32'h00);
    chk("ar_fl",    32'(fl_v), 32'h0);
    chk("ar_cnt",   32'(stall_cycles), 32'd0);
    tick();
    mem_req_m = 1'b0; reset = 1'b0; #1;
    chk("ar_idle",  32'(en_v), 32'h1f);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
